// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Summary  : Loads a length-prefixed little-endian byte stream into the
//            instruction memory, then releases the core reset. Optional
//            trailing XOR checksum is enabled by IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_rst_n
);

    // Word counters must hold both an 8-bit length and the value DEPTH.
    localparam int CW = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
    localparam logic [CW-1:0] C_DEPTH = CW'(1) << ADDR_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd3;
`endif
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        r_state;
    logic [CW-1:0]     r_n;
    logic [CW-1:0]     r_idx;
    logic [1:0]        r_bcnt;
    logic [31:0]       r_word;
    logic              r_err;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic [31:0] w_word_next;
    assign w_word_next = {in_data, r_word[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_idx       <= '0;
            r_bcnt      <= '0;
            r_word      <= '0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_LEN;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                        r_bcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (in_valid) begin
                        if (in_data == 8'd0) begin
                            r_state <= S_DONE;
                        end else if (CW'(in_data) > C_DEPTH) begin
                            r_state <= S_DONE;
                            r_err   <= 1'b1;
                        end else begin
                            r_n     <= CW'(in_data);
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        r_word <= w_word_next;
                        r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ in_data;
`endif
                        // Fourth byte completes a word: write it out next cycle.
                        if (r_bcnt == 2'd3) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_idx[ADDR_W-1:0];
                            r_mem_wdata <= w_word_next;
                            r_idx       <= r_idx + CW'(1);
                            if (r_idx == r_n - CW'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state <= S_CHK;
`else
                                r_state <= S_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (in_valid) begin
                        r_err   <= (in_data != r_csum);
                        r_state <= S_DONE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state == S_LEN) || (r_state == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        || (r_state == S_CHK)
`endif
                        ;
    assign in_ready   = busy;
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign core_rst_n = done && !r_err;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes and final
// status are queued by the stimulus and checked by an independent monitor.
`default_nettype none

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, mem_we, busy, done, err, core_rst_n;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;

    imem_loader #(.ADDR_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .core_rst_n (core_rst_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [37:0] exp_w[$];   // {addr, data}
    bit          exp_f[$];   // expected err at completion
    logic [31:0] wbuf[256];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected or missing", nm);
    endtask

    // Monitor
    logic        prev_done = 1'b0;
    logic [37:0] mon_w;
    bit          mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done <= 1'b0;
        end else begin
            if (mem_we) begin
                if (exp_w.size() == 0) fail("unexpected_write");
                else begin
                    mon_w = exp_w.pop_front();
                    check("write_addr_data", {mem_addr, mem_wdata}, mon_w);
                end
            end
            if (done && !prev_done) begin
                if (exp_f.size() == 0) fail("unexpected_done");
                else begin
                    mon_e = exp_f.pop_front();
                    check("done_err", err, mon_e);
                    check("done_core_rst_n", core_rst_n, !mon_e);
                    check("done_in_ready", in_ready, 0);
                    check("done_busy", busy, 0);
                    check("done_writes_complete", exp_w.size(), 0);
                end
            end
            prev_done <= done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic send(logic [7:0] b);
        int c = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && c < 50) begin
            tick();
            c++;
        end
        if (!in_ready) fail("send_timeout");
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load(int n, bit bad_cs, int gap_at, int gap_len, bit rnd_gaps, int busy_at);
        logic [7:0] cs = 8'd0;
        logic [7:0] b;
        bit e;
        int c = 0;
        pulse_start();
        e = (n > 64);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (n >= 1 && n <= 64 && bad_cs) e = 1'b1;
`endif
        exp_f.push_back(e);
        send(n[7:0]);
        if (n >= 1 && n <= 64) begin
            for (int i = 0; i < n; i++) exp_w.push_back({i[5:0], wbuf[i]});
            for (int k = 0; k < 4 * n; k++) begin
                b = wbuf[k / 4][8 * (k % 4) +: 8];
                cs ^= b;
                if (k == gap_at) idle(gap_len);
                if (k == busy_at) pulse_start();
                if (rnd_gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(b);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send(bad_cs ? (cs ^ 8'h01) : cs);
`endif
        end
        while (!done && c < 100) begin
            tick();
            c++;
        end
        check("done_reached", done, 1);
        idle(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sel;
        idle(2);
        check("reset_outputs", {in_ready, mem_we, busy, done, err, core_rst_n, mem_addr, mem_wdata}, 0);
        rst_n = 1'b1;
        idle(3);
        check("idle_after_reset", {in_ready, busy, done, core_rst_n, mem_we}, 0);

        // Single word
        wbuf[0] = 32'h00500013;
        load(1, 0, -1, 0, 0, -1);
        check("core_rst_n_single", core_rst_n, 1);

        // Two words with a 3-cycle gap mid-word
        wbuf[0] = $urandom;
        wbuf[1] = $urandom;
        load(2, 0, 2, 3, 0, -1);

        // Oversized length
        load(65, 0, -1, 0, 0, -1);
        check("oversize_in_ready", in_ready, 0);
        check("oversize_err", err, 1);

        // Reset in the middle of a load
        wbuf[0] = $urandom;
        wbuf[1] = $urandom;
        pulse_start();
        exp_w.push_back({6'd0, wbuf[0]});
        send(8'd2);
        for (int k = 0; k < 6; k++) send(wbuf[k / 4][8 * (k % 4) +: 8]);
        idle(2);
        check("write_before_reset", exp_w.size(), 0);
        rst_n = 1'b0;
        #1;
        check("reset_mid_load", {in_ready, mem_we, busy, done, err, core_rst_n, mem_addr, mem_wdata}, 0);
        exp_w.delete();
        tick();
        rst_n = 1'b1;
        idle(3);
        check("idle_after_abort", {busy, done, core_rst_n}, 0);
        wbuf[0] = $urandom;
        load(1, 0, -1, 0, 0, -1);

        // start while busy is ignored
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        load(3, 0, -1, 0, 0, 5);
        check("busy_start_core_rst_n", core_rst_n, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wbuf[0] = 32'h00500013;
        load(1, 0, -1, 0, 0, -1);
        check("checksum_good_err", err, 0);
        load(1, 1, -1, 0, 0, -1);
        check("checksum_bad_core_rst_n", core_rst_n, 0);
`endif

        for (int r = 0; r < 12; r++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) n = 0;
            else if (sel == 1) n = $urandom_range(65, 255);
            else if (sel == 2) n = 64;
            else n = $urandom_range(1, 6);
            for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
            load(n, 1'($urandom_range(0, 1)), -1, 0, 1, -1);
        end

        idle(3);
        check("scoreboard_drained", exp_w.size() + exp_f.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
